calc_key_sequencer: RTL
=======================

# calc_key_sequencer

Front-end command sequencer for the calculator datapath. It sits between the raw keypad (ten digit keys plus enter/number/total/clear) and the execution datapath. It edge-detects key presses, arbitrates simultaneous presses, and accumulates a decimal entry into a binary operand. It issues one command at a time to the datapath over a valid/ready handshake and locks out everything except clear while the datapath reports an error.

## Interface
Parameters:
- MAX_DIGITS, 4, maximum decimal digits in one entry.
- ENTRY_W, 14, operand width; must hold 10^MAX_DIGITS − 1 (9999).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- key_digit  in  10  raw digit keys; bit i = digit i.
- key_enter, key_number, key_total, key_clear  in  1 each  raw command keys.
- cmd_valid  out  1  command offered to the datapath.
- cmd_op  out  2  0=ENTER, 1=NUMBER, 2=TOTAL, 3=CLEAR.
- cmd_operand  out  ENTER_W  operand for the command.
- cmd_ready  in  1  datapath accepts the command this cycle.
- dp_err  in  1  datapath error level.
- entry_value  out  ENTRY_W  current accumulated entry (binary).
- entry_digits  out  3  significant digits entered so far.
- key_err  out  1  one-cycle pulse: digit rejected because the entry is full.
- locked  out  1  high in LOCKED state.

## Operation
- Edge detect: prev_keys register (14 bits); press = keys & ~prev_keys. On reset, prev_keys is set to all-ones, so a key held through reset is ignored until it is released.
- Arbitration of same-cycle presses: clear > total > number > enter > digits (lowest index wins). Losing presses are dropped, not queued.
- States:
  - IDLE: collecting digits.
  - ISSUE: cmd_valid high, waiting for cmd_ready.
  - LOCKED: error lockout.
- IDLE, digit d press:
  - If entry_digits < MAX_DIGITS: entry_value ← entry_value*10 + d. entry_digits increments, except for d=0 when entry_digits=0 (leading zeros are not counted).
  - Otherwise: key_err pulses for one cycle; entry is unchanged.
- IDLE, enter/number/total press → ISSUE with cmd_operand = entry_value.
- Any state, clear press:
  - entry_value and entry_digits are zeroed immediately.
  - In IDLE or LOCKED: → ISSUE with op CLEAR, operand 0.
  - In ISSUE: sets clear_pending.
- ISSUE:
  - cmd_op and cmd_operand are stable until the handshake completes (cmd_valid & cmd_ready at a rising edge).
  - Non-clear presses during ISSUE are dropped.
  - On completion:
    - Non-CLEAR commands zero the entry.
    - If clear_pending is set: re-enter ISSUE with CLEAR and clear clear_pending.
    - Else if dp_err is high: → LOCKED.
    - Else: → IDLE.
- dp_err high while in IDLE → LOCKED.
- LOCKED: only clear is accepted; its CLEAR handshake returns to IDLE.
- Arithmetic: entry accumulation never exceeds 9999, so there is no overflow beyond ENTRY_W.

## Timing
- Reset values: cmd_valid=0, cmd_op=0, cmd_operand=0, entry_value=0, entry_digits=0, key_err=0, locked=0, clear_pending=0, state=IDLE.
- Latency: a press sampled at edge k gives cmd_valid=1 and an entry update visible after edge k (one cycle).
- Back-to-back: the earliest next command is offered one cycle after handshake completion. The pending CLEAR is the exception: its cmd_valid stays high with no gap.
- key_err is high for exactly one cycle per rejected digit.
- Reset asserted mid-ISSUE: cmd_valid is 0 after that edge and the command is abandoned.
- cmd_ready while cmd_valid=0 is ignored.

## Structure
- Shared package calc_pkg:
  - cmd_op enum (ENTER/NUMBER/TOTAL/CLEAR).
  - seq_state enum (IDLE/ISSUE/LOCKED).
  - ENTRY_W and MAX_ENTRY=9999 constants.
- Sub-module key_edge_arbiter: edge detect plus fixed-priority select. It outputs a one-cycle press_valid, press_is_digit, press_code[3:0] and a separate clear_press.
- The FSM and entry accumulator stay in the top module.

## Test plan
- Digits 5,0,0 then enter, with cmd_ready held 0 for 3 cycles then 1 → entry_value=500 and entry_digits=3. cmd_valid/ENTER/500 are held stable for 4 cycles; after the handshake the entry is 0 and the state is IDLE.
- Digits 1,2,3,4,5 → entry_value=1234 and key_err pulses once on the 5th digit. Then 0,0 from empty → entry_digits stays 0.
- total and digit 3 pressed in the same cycle → TOTAL issued with the prior operand; digit dropped; entry_value stays 0 afterwards.
- dp_err=1 during the ENTER handshake → locked=1. Then enter and digit 7 → no command, entry unchanged. Then clear → CLEAR, operand 0, locked=0 after the handshake.
- clear pressed while a NUMBER is waiting in ISSUE → NUMBER completes, then CLEAR is offered the next cycle with no gap.
- key_enter held high across reset deassertion → no command until it is released and pressed again. Reset during ISSUE → cmd_valid=0 next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared command/state types and entry constants for the calculator front end
package calc_pkg;
  localparam int MAX_ENTRY = 9999;
  localparam int ENTRY_W = $clog2(MAX_ENTRY + 1);
  typedef enum logic [1:0] {OP_ENTER, OP_NUMBER, OP_TOTAL, OP_CLEAR} cmd_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCKED} seq_state_e;
endpackage

// File: rtl/key_edge_arbiter.sv
// key_edge_arbiter: keypad edge detection with fixed-priority press selection
module key_edge_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_digit,
  input  logic       key_enter,
  input  logic       key_number,
  input  logic       key_total,
  input  logic       key_clear,
  output logic       clear_press,
  output logic       press_valid,
  output logic       press_is_digit,
  output logic [3:0] press_code
);
  import calc_pkg::*;
  logic [13:0] keys, prev_keys, press;
  logic [3:0] digit_code;
  assign keys = {key_clear, key_total, key_number, key_enter, key_digit};
  assign press = keys & ~prev_keys;
  always_ff @(posedge clk) prev_keys <= rst ? '1 : keys;
  always_comb begin
    digit_code = '0;
    for (int i = 9; i >= 0; i--) if (press[i]) digit_code = 4'(i);
  end
  assign clear_press = press[13];
  assign press_valid = !press[13] && |press[12:0];
  assign press_is_digit = !(|press[12:10]);
  assign press_code = press[12] ? 4'(OP_TOTAL) : press[11] ? 4'(OP_NUMBER) : press[10] ? 4'(OP_ENTER) : digit_code;
endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad command sequencer with decimal entry, handshake issue and error lockout
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int ENTRY_W = calc_pkg::ENTRY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         key_digit,
  input  logic               key_enter,
  input  logic               key_number,
  input  logic               key_total,
  input  logic               key_clear,
  output logic               cmd_valid,
  output logic [1:0]         cmd_op,
  output logic [ENTRY_W-1:0] cmd_operand,
  input  logic               cmd_ready,
  input  logic               dp_err,
  output logic [ENTRY_W-1:0] entry_value,
  output logic [2:0]         entry_digits,
  output logic               key_err,
  output logic               locked
);
  import calc_pkg::*;
  seq_state_e state, state_n;
  cmd_op_e op_q, op_n;
  logic [ENTRY_W-1:0] operand_n, value_n;
  logic [2:0] digits_n;
  logic pend, pend_n, pend_any, key_err_n, done;
  logic clear_press, press_valid, press_is_digit;
  logic [3:0] press_code;
  key_edge_arbiter u_arb (
    .clk(clk),
    .rst(reset),
    .key_digit(key_digit),
    .key_enter(key_enter),
    .key_number(key_number),
    .key_total(key_total),
    .key_clear(key_clear),
    .clear_press(clear_press),
    .press_valid(press_valid),
    .press_is_digit(press_is_digit),
    .press_code(press_code)
  );
  assign cmd_valid = state == S_ISSUE;
  assign locked = state == S_LOCKED;
  assign cmd_op = op_q;
  assign done = cmd_valid && cmd_ready;
  assign pend_any = pend || clear_press;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q <= OP_ENTER;
      cmd_operand <= '0;
      entry_value <= '0;
      entry_digits <= '0;
      key_err <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= op_n;
      cmd_operand <= operand_n;
      entry_value <= value_n;
      entry_digits <= digits_n;
      key_err <= key_err_n;
      pend <= pend_n;
    end
  end
  always_comb begin
    state_n = state;
    op_n = op_q;
    operand_n = cmd_operand;
    value_n = entry_value;
    digits_n = entry_digits;
    pend_n = pend;
    key_err_n = 1'b0;
    if (clear_press) begin
      value_n = '0;
      digits_n = '0;
    end
    case (state)
      S_ISSUE: begin
        pend_n = done ? 1'b0 : pend_any;
        if (done) begin
          if (op_q != OP_CLEAR) begin
            value_n = '0;
            digits_n = '0;
          end
          state_n = pend_any ? S_ISSUE : dp_err ? S_LOCKED : S_IDLE;
          op_n = pend_any ? OP_CLEAR : op_q;
          operand_n = pend_any ? '0 : cmd_operand;
        end
      end
      default: begin
        if (clear_press) begin
          state_n = S_ISSUE;
          op_n = OP_CLEAR;
          operand_n = '0;
        end else if (state == S_IDLE && dp_err) state_n = S_LOCKED;
        else if (state == S_IDLE && press_valid && !press_is_digit) begin
          state_n = S_ISSUE;
          op_n = cmd_op_e'(press_code[1:0]);
          operand_n = entry_value;
        end else if (state == S_IDLE && press_valid) begin
          if (entry_digits < 3'(MAX_DIGITS)) begin
            value_n = ENTRY_W'(entry_value * 10 + press_code);
            digits_n = entry_digits + 3'(press_code != 0 || entry_digits != 0);
          end else key_err_n = 1'b1;
        end
      end
    endcase
  end
endmodule
